// File: rtl/tug_pkg.sv
// tug_pkg: shared FSM state encoding and output-width helpers for tug_match.
//   state_t  - IDLE / PLAY / ROUND_END / MATCH_OVER
//   pos_w    - signed rope-position width for a given WIN_POS
//   score_w  - round-score width for a given ROUNDS_TO_WIN
package tug_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, ROUND_END, MATCH_OVER} state_t;

    // One extra bit over the magnitude so that -WIN_POS..+WIN_POS fits as signed.
    function automatic int pos_w(input int win_pos);
        return $clog2(win_pos + 1) + 1;
    endfunction

    function automatic int score_w(input int rounds);
        return $clog2(rounds + 1);
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse: synchronizes a raw asynchronous button and emits one pulse per press.
//   clk   - system clock
//   rst   - asynchronous active-high reset, clears synchronizer and edge history
//   din   - raw asynchronous button
//   pulse - one-cycle pulse on each synchronized rising edge
module btn_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/tug_match.sv
// tug_match: two-player tug-of-war match controller.
//   clk, rst            - clock and asynchronous active-high reset
//   clr                 - synchronous match clear (already in clk domain)
//   start, pbl, pbr     - raw asynchronous start / left / right buttons
//   pos                 - signed rope position, -WIN_POS..+WIN_POS
//   winrnd, right, tie  - round-win pulse, last round winner side, tie pulse
//   score_l, score_r    - round wins per side
//   match_over          - high while the match has been decided
module tug_match import tug_pkg::*; #(
    parameter  int WIN_POS       = 4,
    parameter  int ROUNDS_TO_WIN = 3,
    parameter  int SYNC_STAGES   = 2,
    localparam int POS_W         = pos_w(WIN_POS),
    localparam int SCORE_W       = score_w(ROUNDS_TO_WIN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    pbl,
    input  logic                    pbr,
    output logic signed [POS_W-1:0] pos,
    output logic                    winrnd,
    output logic                    right,
    output logic                    tie,
    output logic [SCORE_W-1:0]      score_l,
    output logic [SCORE_W-1:0]      score_r,
    output logic                    match_over
);

    localparam logic signed [POS_W-1:0] WIN_P     = POS_W'(WIN_POS);
    localparam logic signed [POS_W-1:0] NEG_P     = -WIN_P;
    localparam logic signed [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [SCORE_W-1:0]      SCORE_MAX = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [SCORE_W-1:0]      SCORE_ONE = SCORE_W'(1);

    logic start_p, l_p, r_p;

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_start (.clk(clk), .rst(rst), .din(start), .pulse(start_p));
    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_left  (.clk(clk), .rst(rst), .din(pbl),   .pulse(l_p));
    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_right (.clk(clk), .rst(rst), .din(pbr),   .pulse(r_p));

    state_t                  state_q, state_d;
    logic signed [POS_W-1:0] pos_q, pos_d, pos_step;
    logic [SCORE_W-1:0]      score_l_q, score_l_d, score_r_q, score_r_d, win_score;
    logic                    right_q, right_d, winrnd_q, winrnd_d, tie_q, tie_d;
    logic                    push, win;

    always_comb begin
        // A lone push moves the rope one step; in PLAY pos is strictly inside
        // the win band, so one step can reach but never pass +/-WIN_POS.
        push      = l_p ^ r_p;
        pos_step  = r_p ? pos_q + POS_ONE : pos_q - POS_ONE;
        win       = push && (pos_step == WIN_P || pos_step == NEG_P);
        win_score = (r_p ? score_r_q : score_l_q) + SCORE_ONE;
        state_d   = state_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        right_d   = right_q;
        winrnd_d  = 1'b0;
        tie_d     = 1'b0;
        if (clr) begin
            state_d   = IDLE;
            pos_d     = '0;
            score_l_d = '0;
            score_r_d = '0;
            right_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ROUND_END: begin
                    if (start_p) begin
                        pos_d   = '0;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    tie_d = l_p & r_p;
                    if (push) pos_d = pos_step;
                    if (win) begin
                        winrnd_d  = 1'b1;
                        right_d   = r_p;
                        score_r_d = r_p ? win_score : score_r_q;
                        score_l_d = r_p ? score_l_q : win_score;
                        state_d   = (win_score == SCORE_MAX) ? MATCH_OVER : ROUND_END;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            right_q   <= 1'b0;
            winrnd_q  <= 1'b0;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            right_q   <= right_d;
            winrnd_q  <= winrnd_d;
            tie_q     <= tie_d;
        end
    end

    assign pos        = pos_q;
    assign winrnd     = winrnd_q;
    assign right      = right_q;
    assign tie        = tie_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign match_over = (state_q == MATCH_OVER);

endmodule

// File: tb/tb_tug_match.sv
// tb_tug_match: self-checking bench for tug_match against a press-level model.
module tb_tug_match;

    localparam int W = 4;
    localparam int R = 3;

    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, start = 1'b0, pbl = 1'b0, pbr = 1'b0;
    logic signed [3:0] pos;
    logic winrnd, right, tie, match_over;
    logic [1:0] score_l, score_r;

    logic clr1 = 1'b0, start1 = 1'b0, pbl1 = 1'b0, pbr1 = 1'b0;
    logic signed [1:0] pos1;
    logic winrnd1, right1, tie1, mo1;
    logic [1:0] sl1, sr1;

    tug_match dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .pbl(pbl), .pbr(pbr),
        .pos(pos), .winrnd(winrnd), .right(right), .tie(tie),
        .score_l(score_l), .score_r(score_r), .match_over(match_over)
    );

    tug_match #(.WIN_POS(1), .ROUNDS_TO_WIN(2), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .start(start1), .pbl(pbl1), .pbr(pbr1),
        .pos(pos1), .winrnd(winrnd1), .right(right1), .tie(tie1),
        .score_l(sl1), .score_r(sr1), .match_over(mo1)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int m_pos = 0, m_sl = 0, m_sr = 0;
    bit m_right = 1'b0, m_play = 1'b0, m_over = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " pos"}, int'(pos), m_pos);
        chk({tag, " score_l"}, int'(score_l), m_sl);
        chk({tag, " score_r"}, int'(score_r), m_sr);
        chk({tag, " right"}, int'(right), int'(m_right));
        chk({tag, " match_over"}, int'(match_over), int'(m_over));
    endtask

    task automatic model_clear();
        m_pos = 0; m_sl = 0; m_sr = 0;
        m_right = 1'b0; m_play = 1'b0; m_over = 1'b0;
    endtask

    // One press event: raise the chosen buttons for hold cycles, then let the
    // synchronizers drain; the model decides the outcome of the whole press.
    task automatic press(input string tag, input bit l, input bit r, input bit s, input int hold);
        int nw = 0, nt = 0;
        bit ew = 1'b0, et = 1'b0;
        if (!m_over) begin
            if (!m_play) begin
                if (s) begin m_pos = 0; m_play = 1'b1; end
            end else if (l && r) begin
                et = 1'b1;
            end else if (l || r) begin
                m_pos += r ? 1 : -1;
                if (m_pos == W || m_pos == -W) begin
                    ew = 1'b1;
                    m_right = r;
                    m_play = 1'b0;
                    if (r) m_sr++; else m_sl++;
                    if (m_sl == R || m_sr == R) m_over = 1'b1;
                end
            end
        end
        @(negedge clk);
        pbl = l; pbr = r; start = s;
        for (int i = 1; i <= hold + 5; i++) begin
            @(negedge clk);
            nw += int'(winrnd);
            nt += int'(tie);
            if (i == hold) begin pbl = 1'b0; pbr = 1'b0; start = 1'b0; end
        end
        chk({tag, " winrnd pulses"}, nw, int'(ew));
        chk({tag, " tie pulses"}, nt, int'(et));
        check_all(tag);
    endtask

    task automatic rst_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        check_all({tag, " async"});
        chk({tag, " winrnd"}, int'(winrnd), 0);
        chk({tag, " tie"}, int'(tie), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check_all(tag);
        chk({tag, " winrnd"}, int'(winrnd), 0);
        chk({tag, " tie"}, int'(tie), 0);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check_all("reset");
        chk("reset winrnd", int'(winrnd), 0);
        chk("reset tie", int'(tie), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        press("idle push ignored", 0, 1, 0, 2);
        press("start", 0, 0, 1, 2);
        for (int k = 1; k <= 4; k++) press("pbr step", 0, 1, 0, 1 + k % 3);
        press("round_end push ignored", 0, 1, 0, 2);
        press("restart", 0, 0, 1, 3);
        press("tie", 1, 1, 0, 2);
        press("start in play ignored", 0, 0, 1, 2);
        press("pbl held 20", 1, 0, 0, 20);
        rst_pulse("mid-round rst");
        press("idle after rst", 1, 0, 0, 2);

        for (int rd = 0; rd < 3; rd++) begin
            press("match start", 0, 0, 1, 2);
            for (int k = 0; k < 4; k++) press("match pbr", 0, 1, 0, 1);
        end
        press("over start", 0, 0, 1, 2);
        press("over pbl", 1, 0, 0, 2);
        press("over pbr", 0, 1, 0, 2);
        clr_pulse("clr after match");

        press("pre-clr start", 0, 0, 1, 2);
        press("pre-clr pbr", 0, 1, 0, 2);
        @(negedge clk);
        pbr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pbr = 1'b0;
        model_clear();
        check_all("clr beats pbr");
        repeat (4) @(negedge clk);
        press("idle after clr", 0, 1, 0, 2);

        for (int n = 0; n < 80; n++) begin
            int k;
            k = $urandom_range(0, 9);
            press("random", k >= 2 && k != 8, k >= 5, k < 2, $urandom_range(1, 4));
            if (m_over) clr_pulse("random clr");
        end

        @(negedge clk);
        start1 = 1'b1;
        repeat (3) @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("w1 start pos", int'(pos1), 0);
        pbl1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk("w1 edge3 pos", int'(pos1), 0);
                chk("w1 edge3 winrnd", int'(winrnd1), 0);
            end
            if (i == 4) begin
                chk("w1 edge4 pos", int'(pos1), -1);
                chk("w1 edge4 winrnd", int'(winrnd1), 1);
                chk("w1 edge4 right", int'(right1), 0);
                chk("w1 edge4 score_l", int'(sl1), 1);
            end
            if (i == 5) chk("w1 edge5 winrnd", int'(winrnd1), 0);
        end
        pbl1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tug_match.md
TUG_MATCH -- requirements
Module: tug_match

Interface
REQ-001 Parameter WIN_POS, default 4: rope-end distance; a round is won when pos reaches +WIN_POS (right) or -WIN_POS (left). Legal range is 1..63.
REQ-002 Parameter ROUNDS_TO_WIN, default 3: number of round wins that ends the match. Legal range is 1..15.
REQ-003 Parameter SYNC_STAGES, default 2: flop depth of each input synchronizer. Legal range is 2..4.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  synchronous clear of match, already synchronous to clk; high for one or more cycles.
REQ-007 start  input  1  raw asynchronous button; starts a round.
REQ-008 pbl  input  1  raw asynchronous left-player button.
REQ-009 pbr  input  1  raw asynchronous right-player button.
REQ-010 pos  output  POS_W  signed two's-complement rope position; POS_W = clog2(WIN_POS+1)+1.
REQ-011 winrnd  output  1  one-cycle pulse, registered, on every round win.
REQ-012 right  output  1  winner side of the last round (1 = right); updated with winrnd and held until the next winrnd.
REQ-013 tie  output  1  one-cycle pulse when left and right push pulses coincide in PLAY.
REQ-014 score_l, score_r  output  SCORE_W each  round-win counts; SCORE_W = clog2(ROUNDS_TO_WIN+1).
REQ-015 match_over  output  1  level; high while the state is MATCH_OVER.

Function
REQ-016 Each of start, pbl and pbr shall pass through a SYNC_STAGES-flop synchronizer, then a rising-edge detector producing a one-cycle pulse per press; a held button yields exactly one pulse.
REQ-017 The latency from a raw input first sampled high at edge 1 to the pos/state update shall be SYNC_STAGES+1 edges.
REQ-018 The FSM states shall be IDLE, PLAY, ROUND_END and MATCH_OVER.
REQ-019 In IDLE, a start pulse shall set pos=0 and enter PLAY; push pulses are ignored.
REQ-020 In PLAY: a left pulse alone shall decrement pos; a right pulse alone shall increment pos; both pulses in the same cycle shall leave pos unchanged and pulse tie; start is ignored.
REQ-021 In PLAY, the edge at which pos becomes ±WIN_POS shall also: register winrnd=1 for one cycle; set right; increment the winner's score; and move to ROUND_END.
REQ-022 In that same edge, if the incremented score equals ROUNDS_TO_WIN, the FSM shall move to MATCH_OVER instead of ROUND_END.
REQ-023 In ROUND_END, pos shall hold ±WIN_POS and pushes are ignored; a start pulse shall set pos=0 and enter PLAY.
REQ-024 In MATCH_OVER, all pulses are ignored; only clr or rst exit MATCH_OVER.
REQ-025 clr high at an edge shall set pos=0, scores=0, right=0, winrnd=0, tie=0 and state=IDLE, overriding every simultaneous pulse. Synchronizer and edge-detector flops are not cleared.
REQ-026 pos shall never exceed ±WIN_POS; no arithmetic wrap is permitted.
REQ-027 Scores shall never exceed ROUNDS_TO_WIN.

Reset
REQ-028 While rst is high, all flops shall be forced asynchronously, including synchronizers and edge-detector history, as follows: state=IDLE; pos=0; score_l=score_r=0; right=0; winrnd=0; tie=0; match_over=0.
REQ-029 After rst deasserts, a button already held high shall produce one pulse, because the edge history resets to 0.
REQ-030 rst asserted mid-round shall abandon the round with no winrnd.

Structure
REQ-031 The shared package tug_pkg shall hold the FSM state encoding and the POS_W/SCORE_W width-derivation functions.
REQ-032 One sub-module, btn_pulse (parameter SYNC_STAGES; ports clk, rst, din, pulse), shall be instantiated three times, once each for start, pbl and pbr.

Verification
REQ-033 With defaults: press start, then 4 separate pbr presses -> pos steps 1,2,3,4; winrnd pulses one cycle with right=1 on the 4th; score_r=1; state ROUND_END.
REQ-034 In PLAY at pos=0, pbl and pbr rise in the same cycle -> tie is high for one cycle, pos stays 0, no score change.
REQ-035 Hold pbl high for 20 cycles -> exactly one decrement, pos=-1; assert rst for 1 cycle in that round -> pos=0, winrnd never pulses, state IDLE.
REQ-036 Right wins 3 rounds -> on the 3rd winrnd, match_over=1 and score_r=3; further start, pbl and pbr presses change nothing; clr -> all outputs 0, IDLE.
REQ-037 pbr press with clr high at the update edge -> pos=0, clr wins; and with WIN_POS=1, SYNC_STAGES=3, a single pbl press reaches pos=-1 at exactly edge 4 after the raw rise, with winrnd and right=0.
